fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 167 ++++++++++++++++
 tb/tb_fetch_decode.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and decode front end.
// Issues reads to a one-cycle-latency instruction memory, decodes each returned
// word and queues the result in a small FIFO for the downstream consumer.
// Fetch is credit-limited so every word in flight always has a free buffer slot.
module fetch_decode #(
  parameter int unsigned PC_W  = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [23:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic            alu_sum,
  output logic            wb,
  output logic            mem_wb,
  output logic            op_eq,
  output logic            op_lt,
  output logic            reset_st,
  output logic            set_st,
  output logic [4:0]      dest,
  output logic [4:0]      source1,
  output logic [4:0]      source2,
  output logic [4:0]      source3,
  output logic            halted,
  output logic            illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  // ctrl order: {alu_sum, wb, mem_wb, op_eq, op_lt, reset_st, set_st}
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      ctrl;
    logic [19:0]     regs;
  } entry_t;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic              inflight_q, inflight_d;
  logic              illegal_q, illegal_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  entry_t            mem_q [DEPTH];

  logic [3:0]        op;
  logic [6:0]        dec_ctrl;
  logic              is_halt, is_illegal;
  logic              pop, cap, push;
  int unsigned       occ;
  entry_t            head_entry;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Decode the word returned by memory this cycle.
  always_comb begin
    op         = imem_rdata[23:20];
    dec_ctrl   = '0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      4'd0:    dec_ctrl = 7'b000_0000;
      4'd1:    dec_ctrl = 7'b110_0000;
      4'd2:    dec_ctrl = 7'b011_0000;
      4'd3:    dec_ctrl = 7'b000_1001;
      4'd4:    dec_ctrl = 7'b000_0101;
      4'd5:    dec_ctrl = 7'b000_0010;
      4'd15:   is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  // Fetch credit, capture, FIFO bookkeeping and run/halt control.
  always_comb begin
    pop  = out_valid & out_ready;
    // A redirect drops whatever word is returning in the same cycle.
    cap  = inflight_q & ~redirect;
    push = cap & ~is_halt;
    occ  = 32'(count_q) - 32'(pop) + 32'(inflight_q);

    imem_req  = rst_n & (state_q == StRun) & ~redirect & (occ < DEPTH);
    imem_addr = pc_q;

    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = pc_q;
    inflight_d = imem_req;
    illegal_d  = illegal_q | (cap & is_illegal);
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      state_d    = StRun;
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (imem_req) pc_d = pc_q + PC_W'(1);
      if (cap && is_halt) begin
        // Park on the HALT address and kill the request issued alongside it.
        state_d    = StHalted;
        pc_d       = rsp_pc_q;
        inflight_d = 1'b0;
      end
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Buffer storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{pc: rsp_pc_q, ctrl: dec_ctrl, regs: imem_rdata[19:0]};
    end
  end

  assign head_entry = mem_q[head_q];
  assign out_valid  = (count_q != '0);
  assign out_pc     = head_entry.pc;
  assign {alu_sum, wb, mem_wb, op_eq, op_lt, reset_st, set_st} = head_entry.ctrl;
  assign {dest, source1, source2, source3} = head_entry.regs;
  assign halted     = (state_q == StHalted);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: decode table plus hand-written multi-cycle
// sequences for stall, HALT, redirect, illegal ops, pc wrap and mid-stream reset.
module tb_fetch_decode;

  localparam int unsigned PC_W  = 5;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [23:0]     imem_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            out_valid, out_ready;
  logic [PC_W-1:0] out_pc;
  logic            alu_sum, wb, mem_wb, op_eq, op_lt, reset_st, set_st;
  logic [4:0]      dest, source1, source2, source3;
  logic            halted, illegal;
  logic [6:0]      ctrl;

  logic [23:0]     imem [32];
  int              total  = 0;
  int              passed = 0;

  typedef struct {
    logic [23:0] word;
    logic [6:0]  ctrl;
  } vec_t;
  vec_t vecs [8];

  fetch_decode #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_sum(alu_sum), .wb(wb), .mem_wb(mem_wb), .op_eq(op_eq), .op_lt(op_lt),
    .reset_st(reset_st), .set_st(set_st), .dest(dest), .source1(source1),
    .source2(source2), .source3(source3), .halted(halted), .illegal(illegal)
  );

  assign ctrl = {alu_sum, wb, mem_wb, op_eq, op_lt, reset_st, set_st};

  always #5 clk = ~clk;

  // One-cycle-latency memory; an illegal-op pattern is returned when idle.
  always @(posedge clk) imem_rdata <= imem_req ? imem[imem_addr] : 24'hE00000;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  function automatic logic [23:0] ins(input logic [3:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] s3);
    return {op, d, s1, s2, s3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic fill_default();
    for (int i = 0; i < 32; i++) imem[i] = ins(4'd0, 5'(i), 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    out_ready = rdy;
    repeat (2) @(negedge clk);
  endtask

  // Wait (bounded) for a valid head, check it, then let it pop at the next edge.
  task automatic next_out(input logic [PC_W-1:0] epc, input logic [6:0] ectrl,
                          input logic [4:0] edest, input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, " valid"}, 32'(out_valid), 32'd1);
    end else begin
      chk({nm, " pc"}, 32'(out_pc), 32'(epc));
      chk({nm, " ctrl"}, 32'(ctrl), 32'(ectrl));
      chk({nm, " dest"}, 32'(dest), 32'(edest));
    end
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    logic unstable;

    vecs[0] = '{word: ins(4'd0, 5'd5, 5'd1, 5'd1, 5'd1), ctrl: 7'b000_0000};
    vecs[1] = '{word: ins(4'd1, 5'd6, 5'd2, 5'd3, 5'd0), ctrl: 7'b110_0000};
    vecs[2] = '{word: ins(4'd2, 5'd7, 5'd4, 5'd0, 5'd0), ctrl: 7'b011_0000};
    vecs[3] = '{word: ins(4'd3, 5'd8, 5'd1, 5'd2, 5'd0), ctrl: 7'b000_1001};
    vecs[4] = '{word: ins(4'd4, 5'd9, 5'd3, 5'd4, 5'd0), ctrl: 7'b000_0101};
    vecs[5] = '{word: ins(4'd5, 5'd10, 5'd0, 5'd0, 5'd0), ctrl: 7'b000_0010};
    vecs[6] = '{word: ins(4'd6, 5'd11, 5'd0, 5'd0, 5'd0), ctrl: 7'b000_0000};
    vecs[7] = '{word: ins(4'd14, 5'd12, 5'd0, 5'd0, 5'd0), ctrl: 7'b000_0000};

    redirect_pc = '0;
    fill_default();
    imem[0] = ins(4'd1, 5'd1, 5'd2, 5'd3, 5'd0);
    imem[1] = ins(4'd2, 5'd4, 5'd5, 5'd0, 5'd0);

    // Reset state and first-fetch latency.
    do_reset(1'b1);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    chk("lat1 out_valid", 32'(out_valid), 32'd0);
    chk("second addr", 32'(imem_addr), 32'd1);
    @(negedge clk);
    chk("add valid", 32'(out_valid), 32'd1);
    chk("add pc", 32'(out_pc), 32'd0);
    chk("add ctrl", 32'(ctrl), 32'b110_0000);
    chk("add dest", 32'(dest), 32'd1);
    chk("add src1", 32'(source1), 32'd2);
    chk("add src2", 32'(source2), 32'd3);
    @(negedge clk);
    chk("load valid", 32'(out_valid), 32'd1);
    chk("load pc", 32'(out_pc), 32'd1);
    chk("load ctrl", 32'(ctrl), 32'b011_0000);
    chk("load dest", 32'(dest), 32'd4);
    chk("no illegal yet", 32'(illegal), 32'd0);

    // Decode table at address 8, entered by a mid-stream redirect.
    for (int i = 0; i < 8; i++) imem[8 + i] = vecs[i].word;
    redirect = 1'b1;
    redirect_pc = 5'd8;
    #1;
    chk("redir no req", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    chk("redir flush", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      next_out(5'(8 + i), vecs[i].ctrl, vecs[i].word[19:15], "decode");
    end
    chk("table illegal", 32'(illegal), 32'd1);

    // Stall: buffer fills to DEPTH, fields hold, drain in order, resume at DEPTH.
    fill_default();
    imem[0] = ins(4'd1, 5'd1, 5'd2, 5'd3, 5'd0);
    imem[1] = ins(4'd4, 5'd9, 5'd0, 5'd0, 5'd0);
    do_reset(1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall valid", 32'(out_valid), 32'd1);
    chk("stall pc", 32'(out_pc), 32'd0);
    seen = 1'b0;
    unstable = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
      if (out_pc !== 5'd0 || dest !== 5'd1 || ctrl !== 7'b110_0000 || !out_valid)
        unstable = 1'b1;
    end
    chk("stall no req", 32'(seen), 32'd0);
    chk("stall hold", 32'(unstable), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("resume req", 32'(imem_req), 32'd1);
    chk("resume addr", 32'(imem_addr), 32'(DEPTH));
    next_out(5'd0, 7'b110_0000, 5'd1, "drain0");
    next_out(5'd1, 7'b000_0101, 5'd9, "drain1");
    next_out(5'd2, 7'b000_0000, 5'd2, "drain2");

    // HALT at address 3, then redirect to 7.
    fill_default();
    imem[3] = ins(4'd15, 5'd0, 5'd0, 5'd0, 5'd0);
    imem[4] = ins(4'd1, 5'd7, 5'd0, 5'd0, 5'd0);
    do_reset(1'b1);
    rst_n = 1'b1;
    next_out(5'd0, 7'd0, 5'd0, "pre-halt0");
    next_out(5'd1, 7'd0, 5'd1, "pre-halt1");
    next_out(5'd2, 7'd0, 5'd2, "pre-halt2");
    chk("halted", 32'(halted), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      if (imem_req || out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("halt quiet", 32'(seen), 32'd0);
    redirect = 1'b1;
    redirect_pc = 5'd7;
    @(negedge clk);
    redirect = 1'b0;
    chk("unhalt", 32'(halted), 32'd0);
    #1;
    chk("unhalt req", 32'(imem_req), 32'd1);
    chk("unhalt addr", 32'(imem_addr), 32'd7);
    next_out(5'd7, 7'd0, 5'd7, "after-halt");

    // Redirect with a full buffer and one word in flight.
    fill_default();
    do_reset(1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("full valid", 32'(out_valid), 32'd1);
    chk("full no req", 32'(imem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 5'd20;
    out_ready = 1'b1;
    #1;
    chk("inflight redir req", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    chk("inflight flush", 32'(out_valid), 32'd0);
    next_out(5'd20, 7'd0, 5'd20, "post-redir");

    // Illegal op at address 0 is delivered with zero controls and sticks.
    fill_default();
    imem[0] = ins(4'd9, 5'd3, 5'd1, 5'd2, 5'd4);
    do_reset(1'b1);
    rst_n = 1'b1;
    next_out(5'd0, 7'd0, 5'd3, "illegal op");
    chk("illegal set", 32'(illegal), 32'd1);
    repeat (4) @(negedge clk);
    chk("illegal held", 32'(illegal), 32'd1);

    // pc wrap from 31 to 0, then reset mid-stream.
    redirect = 1'b1;
    redirect_pc = 5'd31;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("wrap req31", 32'(imem_req), 32'd1);
    chk("wrap addr31", 32'(imem_addr), 32'd31);
    @(negedge clk);
    chk("wrap req0", 32'(imem_req), 32'd1);
    chk("wrap addr0", 32'(imem_addr), 32'd0);
    chk("illegal pre-rst", 32'(illegal), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst illegal", 32'(illegal), 32'd0);
    chk("midrst req", 32'(imem_req), 32'd0);
    chk("midrst halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst addr", 32'(imem_addr), 32'd0);
    next_out(5'd0, 7'd0, 5'd3, "post-rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
